transmit_ethernet_packet: RTL and testbench
===========================================

// Module: transmit_ethernet_packet
// PURPOSE
// - TX counterpart of the packet receiver: takes a user payload stream of 16-bit words and emits a complete frame body to the TX/MAC interface.
// - Prepends a fixed HDR_WORDS header (dest MAC, src MAC, EtherType, payload length, zero fill), streams the payload and zero-pads short frames.
// - Holds tx_req_out for the whole frame; the MAC appends the FCS and signals completion.
// PARAMETERS
// - HDR_WORDS      18              header words sent before the payload (matches the receiver's header dump)
// - DEST_MAC       48'hFFFF_FFFF_FFFF  destination MAC, header words 0-2, MSW first
// - SRC_MAC        48'h0002_0304_0506  source MAC, header words 3-5
// - ETHERTYPE      16'h88B5        header word 6
// - MIN_PAY_WORDS  12              minimum payload words (frame >= 60 bytes pre-FCS); shortfall zero-padded
// - MAX_PAY_WORDS  739             maximum payload words; longer requests saturate
// PORTS
// - Clock                      in   1   system clock
// - Reset_n                    in   1   asynchronous active-low reset
// - ethernet_snd_req_in        in   1   start a frame; sampled in IDLE only
// - ethernet_snd_length_in     in   11  payload words; latched with the request
// - ethernet_snd_data_in       in   16  payload word
// - ethernet_snd_data_rdy_in   in   1   payload word valid
// - ethernet_snd_data_ack_out  out  1   payload word consumed this cycle
// - ethernet_snd_busy_out      out  1   high from the accepted request until COMPLETE exits
// - ethernet_snd_complete_out  out  1   one-cycle pulse when the frame is done
// - tx_req_out                 out  1   TX interface owned for this frame
// - tx_packet_data_out         out  16  word to the MAC
// - tx_packet_data_rdy_out     out  1   tx_packet_data_out valid
// - tx_packet_last_out         out  1   marks the final word of the frame body
// - tx_packet_data_ack_in      in   1   MAC accepted the word (transfer = rdy & ack)
// - tx_packet_complete_in      in   1   MAC finished transmitting, FCS included
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, counters=0, all outputs 0. Reset during a frame aborts it with no complete pulse.
// - IDLE: on req, latch len = min(length_in, MAX_PAY_WORDS); word_cnt=0; go to HDR. Requests outside IDLE are ignored.
// - HDR: rdy_out=1; data = header[word_cnt]. Word 7 = len; words 8..HDR_WORDS-1 = 0. Each transfer increments word_cnt.
//   After word HDR_WORDS-1 transfers: word_cnt=0, then go to DATA if len>0, else PAD.
// - DATA: combinational passthrough. tx data = snd data; tx rdy = snd rdy; snd ack = tx ack & snd rdy.
//   Each transfer increments word_cnt. After word len-1: go to PAD if len<MIN_PAY_WORDS, else WAIT.
// - PAD: rdy_out=1, data=0, until word_cnt reaches MIN_PAY_WORDS; then go to WAIT.
// - last_out=1 on exactly the final presented word: last pad word, last data word if len>=MIN, never on header words.
// - WAIT: tx_req held, rdy_out=0. On tx_packet_complete_in go to COMPLETE; complete arriving earlier is ignored.
// - COMPLETE: complete_out=1 for one cycle, tx_req dropped, return to IDLE. The next req is accepted the following cycle.
// - tx_req_out = (state != IDLE && state != COMPLETE). Data words hold stable while rdy & !ack.
// - Latency: req at cycle N gives first header word valid at N+1. With ack held high, frame = HDR_WORDS + max(len,MIN) cycles.
// - word_cnt is 11 bits, never wraps (max 739). Length 0 gives header + 12 pad words.
// STRUCTURE
// - Shared package eth_pkg: state encoding (IDLE, HDR, DATA, PAD, WAIT, COMPLETE), HDR_WORDS, MIN/MAX_PAY_WORDS, default MACs and EtherType.
// - Sub-module eth_tx_header_rom: combinational word index -> header word from parameters and len.
// - Top: FSM, word counter, datapath mux.
// TESTING
// - len=20, ack always high, user rdy always high -> 18 hdr words (0-2 FFFF, 6 88B5, 7 0014), 20 data words, last on the 20th, complete one cycle after tx_complete.
// - len=3 -> 3 data words, then 9 zero pad words; last only on the 12th payload word; word 7 = 0003.
// - len=0 -> header, then 12 zero words, no snd ack ever asserted.
// - len=2000 -> word 7 = 02E3, exactly 739 data acks.
// - Random ack/rdy throttling -> data stable while stalled, no lost or duplicated words, req ignored while busy.
// - Reset_n low mid-DATA -> all outputs 0 immediately, no complete pulse; a new req after release starts a clean frame.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path: FSM state encoding,
// frame geometry and the default addressing used in the header.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_DATA     = 3'd2,
    ST_PAD      = 3'd3,
    ST_WAIT     = 3'd4,
    ST_COMPLETE = 3'd5
  } eth_tx_state_t;

  localparam int          ETH_HDR_WORDS     = 18;
  localparam int          ETH_MIN_PAY_WORDS = 12;
  localparam int          ETH_MAX_PAY_WORDS = 739;
  localparam logic [47:0] ETH_DEST_MAC      = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] ETH_SRC_MAC       = 48'h0002_0304_0506;
  localparam logic [15:0] ETH_ETHERTYPE     = 16'h88B5;

  // Clamp a requested payload length to the largest frame we can send.
  function automatic logic [10:0] sat_len(input logic [10:0] req_len,
                                          input logic [10:0] max_len);
    return (req_len > max_len) ? max_len : req_len;
  endfunction

endpackage

// File: rtl/transmit_ethernet_packet_if.sv
// User payload stream plus TX/MAC handshake for the Ethernet transmitter.
// master = the transmitter, slave = user logic and MAC on the other side.
interface transmit_ethernet_packet_if;

  logic        ethernet_snd_req_in;
  logic [10:0] ethernet_snd_length_in;
  logic [15:0] ethernet_snd_data_in;
  logic        ethernet_snd_data_rdy_in;
  logic        ethernet_snd_data_ack_out;
  logic        ethernet_snd_busy_out;
  logic        ethernet_snd_complete_out;
  logic        tx_req_out;
  logic [15:0] tx_packet_data_out;
  logic        tx_packet_data_rdy_out;
  logic        tx_packet_last_out;
  logic        tx_packet_data_ack_in;
  logic        tx_packet_complete_in;

  modport master (
    input  ethernet_snd_req_in, ethernet_snd_length_in, ethernet_snd_data_in,
           ethernet_snd_data_rdy_in, tx_packet_data_ack_in, tx_packet_complete_in,
    output ethernet_snd_data_ack_out, ethernet_snd_busy_out, ethernet_snd_complete_out,
           tx_req_out, tx_packet_data_out, tx_packet_data_rdy_out, tx_packet_last_out
  );

  modport slave (
    output ethernet_snd_req_in, ethernet_snd_length_in, ethernet_snd_data_in,
           ethernet_snd_data_rdy_in, tx_packet_data_ack_in, tx_packet_complete_in,
    input  ethernet_snd_data_ack_out, ethernet_snd_busy_out, ethernet_snd_complete_out,
           tx_req_out, tx_packet_data_out, tx_packet_data_rdy_out, tx_packet_last_out
  );

endinterface

// File: rtl/eth_tx_header_rom.sv
// Combinational header lookup: word index -> header word. Words 0-5 are the
// MAC addresses MSW first, 6 the EtherType, 7 the payload length, rest zero.
module eth_tx_header_rom
  import eth_pkg::*;
#(
  parameter logic [47:0] DEST_MAC  = ETH_DEST_MAC,
  parameter logic [47:0] SRC_MAC   = ETH_SRC_MAC,
  parameter logic [15:0] ETHERTYPE = ETH_ETHERTYPE
) (
  input  logic [10:0] word_idx,
  input  logic [10:0] pay_len,
  output logic [15:0] hdr_word
);

  logic [15:0] hdr_table [0:7];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_mac
      assign hdr_table[gi]     = DEST_MAC[47-16*gi -: 16];
      assign hdr_table[gi + 3] = SRC_MAC[47-16*gi -: 16];
    end
  endgenerate

  assign hdr_table[6] = ETHERTYPE;
  assign hdr_table[7] = {5'd0, pay_len};

  // Indices past the populated table are the zero fill of the header.
  always_comb begin
    hdr_word = (word_idx < 11'd8) ? hdr_table[word_idx[2:0]] : 16'h0000;
  end

endmodule

// File: rtl/transmit_ethernet_packet.sv
// Ethernet frame transmitter: sends a fixed header, passes the user payload
// through, zero-pads short frames, then holds the TX interface until the MAC
// reports the frame (FCS included) is on the wire.
module transmit_ethernet_packet
  import eth_pkg::*;
#(
  parameter int          HDR_WORDS     = ETH_HDR_WORDS,
  parameter logic [47:0] DEST_MAC      = ETH_DEST_MAC,
  parameter logic [47:0] SRC_MAC       = ETH_SRC_MAC,
  parameter logic [15:0] ETHERTYPE     = ETH_ETHERTYPE,
  parameter int          MIN_PAY_WORDS = ETH_MIN_PAY_WORDS,
  parameter int          MAX_PAY_WORDS = ETH_MAX_PAY_WORDS
) (
  input logic                          Clock,
  input logic                          Reset_n,
  transmit_ethernet_packet_if.master   eth
);

  localparam logic [10:0] HDR_LAST = 11'(HDR_WORDS - 1);
  localparam logic [10:0] MIN_PAY  = 11'(MIN_PAY_WORDS);
  localparam logic [10:0] PAD_LAST = 11'(MIN_PAY_WORDS - 1);
  localparam logic [10:0] MAX_PAY  = 11'(MAX_PAY_WORDS);

  eth_tx_state_t state_reg, state_next;
  logic [10:0]   word_cnt_reg, word_cnt_next;
  logic [10:0]   len_reg, len_next;
  logic [15:0]   hdr_word;

  logic        tx_req;
  logic        tx_rdy;
  logic        tx_last;
  logic [15:0] tx_data;
  logic        snd_ack;
  logic        snd_complete;
  logic        tx_xfer;
  logic        hdr_done;
  logic        data_done;
  logic        pad_done;

  eth_tx_header_rom #(
    .DEST_MAC  (DEST_MAC),
    .SRC_MAC   (SRC_MAC),
    .ETHERTYPE (ETHERTYPE)
  ) u_hdr_rom (
    .word_idx (word_cnt_reg),
    .pay_len  (len_reg),
    .hdr_word (hdr_word)
  );

  // Word position decodes; data_done is only consulted in DATA where len_reg > 0.
  assign hdr_done  = (word_cnt_reg == HDR_LAST);
  assign data_done = (word_cnt_reg == (len_reg - 11'd1));
  assign pad_done  = (word_cnt_reg == PAD_LAST);
  assign tx_xfer   = tx_rdy & eth.tx_packet_data_ack_in;

  // State, word counter and latched length registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      len_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      len_reg      <= len_next;
    end
  end

  // Next state, word count and length; the counter restarts at the payload.
  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    len_next      = len_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (eth.ethernet_snd_req_in) begin
          len_next      = sat_len(eth.ethernet_snd_length_in, MAX_PAY);
          word_cnt_next = '0;
          state_next    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (tx_xfer) begin
          if (hdr_done) begin
            word_cnt_next = '0;
            state_next    = (len_reg != 11'd0) ? ST_DATA : ST_PAD;
          end else begin
            word_cnt_next = word_cnt_reg + 11'd1;
          end
        end
      end
      ST_DATA: begin
        if (tx_xfer) begin
          word_cnt_next = word_cnt_reg + 11'd1;
          if (data_done) begin
            state_next = (len_reg < MIN_PAY) ? ST_PAD : ST_WAIT;
          end
        end
      end
      ST_PAD: begin
        if (tx_xfer) begin
          word_cnt_next = word_cnt_reg + 11'd1;
          if (pad_done) begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (eth.tx_packet_complete_in) begin
          state_next = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode; DATA is a combinational passthrough of the user stream.
  always_comb begin
    tx_req       = 1'b0;
    tx_rdy       = 1'b0;
    tx_last      = 1'b0;
    tx_data      = 16'h0000;
    snd_ack      = 1'b0;
    snd_complete = 1'b0;
    unique case (state_reg)
      ST_HDR: begin
        tx_req  = 1'b1;
        tx_rdy  = 1'b1;
        tx_data = hdr_word;
      end
      ST_DATA: begin
        tx_req  = 1'b1;
        tx_rdy  = eth.ethernet_snd_data_rdy_in;
        tx_data = eth.ethernet_snd_data_in;
        snd_ack = eth.tx_packet_data_ack_in & eth.ethernet_snd_data_rdy_in;
        tx_last = data_done & (len_reg >= MIN_PAY);
      end
      ST_PAD: begin
        tx_req  = 1'b1;
        tx_rdy  = 1'b1;
        tx_last = pad_done;
      end
      ST_WAIT: begin
        tx_req = 1'b1;
      end
      ST_COMPLETE: begin
        snd_complete = 1'b1;
      end
      default: begin
        tx_req = 1'b0;
      end
    endcase
  end

  assign eth.tx_req_out                = tx_req;
  assign eth.tx_packet_data_rdy_out    = tx_rdy;
  assign eth.tx_packet_data_out        = tx_data;
  assign eth.tx_packet_last_out        = tx_last;
  assign eth.ethernet_snd_data_ack_out = snd_ack;
  assign eth.ethernet_snd_complete_out = snd_complete;
  assign eth.ethernet_snd_busy_out     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_transmit_ethernet_packet.sv
// Directed bench for transmit_ethernet_packet: full frames with known header
// contents, padding, saturation, throttled handshakes and a mid-frame reset.
module tb_transmit_ethernet_packet;

  logic Clock = 1'b0;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;

  transmit_ethernet_packet_if eth_bus ();

  transmit_ethernet_packet dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .eth     (eth_bus)
  );

  always #5 Clock = ~Clock;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected word idx of a frame whose payload word p is 16'hA000 + p.
  function automatic logic [15:0] exp_word(input int idx, input int plen,
                                           input logic [15:0] len_word);
    int p;
    case (idx)
      0, 1, 2: return 16'hFFFF;
      3:       return 16'h0002;
      4:       return 16'h0304;
      5:       return 16'h0506;
      6:       return 16'h88B5;
      7:       return len_word;
      default: begin
        if (idx < 18) return 16'h0000;
        p = idx - 18;
        if (p < plen) return 16'(32'hA000 + p);
        return 16'h0000;
      end
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_tx_req"},   eth_bus.tx_req_out, 0);
    check_value({tag, "_tx_rdy"},   eth_bus.tx_packet_data_rdy_out, 0);
    check_value({tag, "_tx_data"},  eth_bus.tx_packet_data_out, 0);
    check_value({tag, "_tx_last"},  eth_bus.tx_packet_last_out, 0);
    check_value({tag, "_snd_ack"},  eth_bus.ethernet_snd_data_ack_out, 0);
    check_value({tag, "_busy"},     eth_bus.ethernet_snd_busy_out, 0);
    check_value({tag, "_complete"}, eth_bus.ethernet_snd_complete_out, 0);
  endtask

  // Runs one frame from IDLE; call while the clock is low.
  task automatic run_frame(input logic [10:0] req_len, input int plen,
                           input logic [15:0] len_word, input bit throttle);
    int total, widx, pay_idx, cycles, acks;
    bit in_pay, exp_rdy;
    total   = 18 + ((plen > 12) ? plen : 12);
    widx    = 0;
    pay_idx = 0;
    cycles  = 0;
    acks    = 0;
    check_value("idle_busy", eth_bus.ethernet_snd_busy_out, 0);
    eth_bus.ethernet_snd_req_in    = 1'b1;
    eth_bus.ethernet_snd_length_in = req_len;
    eth_bus.tx_packet_data_ack_in  = 1'b0;
    eth_bus.ethernet_snd_data_rdy_in = 1'b0;
    eth_bus.tx_packet_complete_in  = 1'b0;
    @(negedge Clock);
    eth_bus.ethernet_snd_req_in = 1'b0;
    check_value("start_busy", eth_bus.ethernet_snd_busy_out, 1);
    check_value("start_tx_req", eth_bus.tx_req_out, 1);
    while (widx < total && cycles < 5000) begin
      eth_bus.tx_packet_data_ack_in    = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      eth_bus.ethernet_snd_data_rdy_in = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (throttle) begin
        eth_bus.ethernet_snd_req_in    = 1'($urandom_range(0, 1));
        eth_bus.ethernet_snd_length_in = 11'd5;
        eth_bus.tx_packet_complete_in  = 1'($urandom_range(0, 1));
      end
      eth_bus.ethernet_snd_data_in = 16'(32'hA000 + pay_idx);
      #1;
      in_pay  = (widx >= 18) && (widx < 18 + plen);
      exp_rdy = in_pay ? eth_bus.ethernet_snd_data_rdy_in : 1'b1;
      check_value($sformatf("rdy[%0d]", widx), eth_bus.tx_packet_data_rdy_out, exp_rdy);
      check_value($sformatf("snd_ack[%0d]", widx), eth_bus.ethernet_snd_data_ack_out,
                  in_pay & eth_bus.ethernet_snd_data_rdy_in & eth_bus.tx_packet_data_ack_in);
      if (exp_rdy) begin
        check_value($sformatf("data[%0d]", widx), eth_bus.tx_packet_data_out,
                    exp_word(widx, plen, len_word));
        check_value($sformatf("last[%0d]", widx), eth_bus.tx_packet_last_out,
                    (widx == total - 1));
      end
      if (eth_bus.ethernet_snd_data_ack_out) acks++;
      if (exp_rdy && eth_bus.tx_packet_data_ack_in) begin
        widx++;
        if (in_pay) pay_idx++;
      end
      @(negedge Clock);
      cycles++;
    end
    if (cycles >= 5000) check_value("frame_timeout", widx, total);
    eth_bus.ethernet_snd_req_in      = 1'b0;
    eth_bus.tx_packet_complete_in    = 1'b0;
    eth_bus.tx_packet_data_ack_in    = 1'b1;
    eth_bus.ethernet_snd_data_rdy_in = 1'b1;
    #1;
    check_value("wait_tx_req", eth_bus.tx_req_out, 1);
    check_value("wait_rdy", eth_bus.tx_packet_data_rdy_out, 0);
    check_value("wait_snd_ack", eth_bus.ethernet_snd_data_ack_out, 0);
    check_value("wait_complete", eth_bus.ethernet_snd_complete_out, 0);
    @(negedge Clock);
    check_value("wait2_tx_req", eth_bus.tx_req_out, 1);
    eth_bus.tx_packet_complete_in = 1'b1;
    #1;
    check_value("pre_complete", eth_bus.ethernet_snd_complete_out, 0);
    @(negedge Clock);
    eth_bus.tx_packet_complete_in = 1'b0;
    #1;
    check_value("complete_pulse", eth_bus.ethernet_snd_complete_out, 1);
    check_value("complete_tx_req", eth_bus.tx_req_out, 0);
    check_value("complete_busy", eth_bus.ethernet_snd_busy_out, 1);
    @(negedge Clock);
    #1;
    check_value("post_complete", eth_bus.ethernet_snd_complete_out, 0);
    check_value("post_busy", eth_bus.ethernet_snd_busy_out, 0);
    check_value("payload_acks", acks, plen);
    $display("frame req_len=%0d words=%0d acks=%0d cycles=%0d", req_len, widx, acks, cycles);
  endtask

  initial begin
    Reset_n = 1'b0;
    eth_bus.ethernet_snd_req_in      = 1'b0;
    eth_bus.ethernet_snd_length_in   = '0;
    eth_bus.ethernet_snd_data_in     = '0;
    eth_bus.ethernet_snd_data_rdy_in = 1'b0;
    eth_bus.tx_packet_data_ack_in    = 1'b0;
    eth_bus.tx_packet_complete_in    = 1'b0;
    repeat (3) @(negedge Clock);
    check_outputs_zero("reset");
    Reset_n = 1'b1;
    @(negedge Clock);

    run_frame(11'd20,   20,  16'h0014, 1'b0);
    run_frame(11'd3,    3,   16'h0003, 1'b0);
    run_frame(11'd0,    0,   16'h0000, 1'b0);
    run_frame(11'd2000, 739, 16'h02E3, 1'b0);
    run_frame(11'd15,   15,  16'h000F, 1'b1);
    run_frame(11'd7,    7,   16'h0007, 1'b1);

    // Abort a frame in the middle of its payload.
    @(negedge Clock);
    eth_bus.ethernet_snd_req_in      = 1'b1;
    eth_bus.ethernet_snd_length_in   = 11'd20;
    eth_bus.tx_packet_data_ack_in    = 1'b1;
    eth_bus.ethernet_snd_data_rdy_in = 1'b1;
    eth_bus.ethernet_snd_data_in     = 16'h5A5A;
    @(negedge Clock);
    eth_bus.ethernet_snd_req_in = 1'b0;
    repeat (22) @(negedge Clock);
    #1;
    check_value("mid_data_rdy", eth_bus.tx_packet_data_rdy_out, 1);
    check_value("mid_data_snd_ack", eth_bus.ethernet_snd_data_ack_out, 1);
    Reset_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    eth_bus.tx_packet_complete_in = 1'b1;
    @(negedge Clock);
    check_value("abort_no_complete", eth_bus.ethernet_snd_complete_out, 0);
    #1;
    Reset_n = 1'b1;
    eth_bus.tx_packet_complete_in = 1'b0;
    @(negedge Clock);
    check_value("abort_idle_busy", eth_bus.ethernet_snd_busy_out, 0);
    check_value("abort_idle_complete", eth_bus.ethernet_snd_complete_out, 0);
    $display("frame aborted by reset during payload");

    run_frame(11'd3, 3, 16'h0003, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
